// File: rtl/grf_writeback.sv
// ---------------------------------------------------------------------------
// grf_writeback
//
// Sink end of the writeback path: a 32 x 32-bit general register file.
// Writes land on the rising clock edge. Reads are combinational on two
// independent ports. Register $0 always reads as zero.
//
// Optional feature macro: GRF_BYPASS_EN
//   defined   - a write issued this cycle is forwarded to RD1/RD2 in the
//               same cycle (write-to-read bypass)
//   undefined - reads return the stored contents only; a value written in
//               cycle N becomes visible in cycle N+1
//
// Ports:
//   clk    in   1   system clock, all state updates on the rising edge
//   reset  in   1   synchronous active-high clear of every register
//   WE     in   1   write enable from writeback control
//   A3     in   5   write address (already selected upstream)
//   WD     in  32   write data (already selected upstream)
//   A1     in   5   read address, port 1 (rs)
//   A2     in   5   read address, port 2 (rt)
//   RD1    out 32   read data, port 1
//   RD2    out 32   read data, port 2
// ---------------------------------------------------------------------------
module grf_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [4:0]  A3,
    input  logic [31:0] WD,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2
);

    // Entry 0 is only ever cleared, never written, and reads of address 0
    // are forced to zero regardless.
    logic [31:0] regs_r [0:31];
    logic        wr_en_s;
    logic [31:0] rd1_s;
    logic [31:0] rd2_s;

    // A write qualifies only with WE set and a non-zero destination; with
    // WE low neither A3 nor WD can reach any state.
    assign wr_en_s = WE && (A3 != 5'd0);

    // Register array update: reset has priority and discards any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            regs_r[A3] <= WD;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Read port 1: optional same-cycle forwarding, then $0 and array read.
    always_comb begin
        rd1_s = 32'd0;
`ifdef GRF_BYPASS_EN
        if (wr_en_s && (A1 == A3)) begin
            rd1_s = WD;
        end else if (A1 == 5'd0) begin
            rd1_s = 32'd0;
        end else begin
            rd1_s = regs_r[A1];
        end
`else
        if (A1 == 5'd0) begin
            rd1_s = 32'd0;
        end else begin
            rd1_s = regs_r[A1];
        end
`endif
    end

    // Read port 2: identical rule to port 1, evaluated independently.
    always_comb begin
        rd2_s = 32'd0;
`ifdef GRF_BYPASS_EN
        if (wr_en_s && (A2 == A3)) begin
            rd2_s = WD;
        end else if (A2 == 5'd0) begin
            rd2_s = 32'd0;
        end else begin
            rd2_s = regs_r[A2];
        end
`else
        if (A2 == 5'd0) begin
            rd2_s = 32'd0;
        end else begin
            rd2_s = regs_r[A2];
        end
`endif
    end

    assign RD1 = rd1_s;
    assign RD2 = rd2_s;

endmodule

// File: tb/tb_grf_writeback.sv
// ---------------------------------------------------------------------------
// tb_grf_writeback
//
// Scoreboard bench for grf_writeback. The stimulus process applies one set
// of inputs per cycle, computes the expected read data from a plain array
// model of the register file and pushes it into a queue. A monitor process
// samples RD1/RD2 on every falling edge and compares against the queue head.
// ---------------------------------------------------------------------------
module tb_grf_writeback;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;

    typedef struct packed {
        logic [31:0] e1;
        logic [31:0] e2;
        logic [15:0] tag;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl [32];
    int          n_checks;
    int          n_errors;
    bit          stim_done;

    grf_writeback dut (
        .clk   (clk),
        .reset (reset),
        .WE    (WE),
        .A3    (A3),
        .WD    (WD),
        .A1    (A1),
        .A2    (A2),
        .RD1   (RD1),
        .RD2   (RD2)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference read: architectural rule, plus same-cycle forwarding when
    // the bypass build is selected.
    function automatic logic [31:0] model_read(input logic [4:0] a,
                                               input logic we,
                                               input logic [4:0] a3,
                                               input logic [31:0] wd);
`ifdef GRF_BYPASS_EN
        if (we && a3 != 5'd0 && a == a3) return wd;
`endif
        if (a == 5'd0) return 32'd0;
        return mdl[a];
    endfunction

    // One cycle of stimulus: drive inputs just after the rising edge,
    // queue the expectation, then commit the edge's effect to the model.
    task automatic step(input logic r, input logic we, input logic [4:0] a3,
                        input logic [31:0] wd, input logic [4:0] a1,
                        input logic [4:0] a2, input bit chk, input int tag);
        exp_t e;
        reset = r; WE = we; A3 = a3; WD = wd; A1 = a1; A2 = a2;
        if (chk) begin
            e.e1  = model_read(a1, we, a3, wd);
            e.e2  = model_read(a2, we, a3, wd);
            e.tag = 16'(tag);
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        end else if (we && a3 != 5'd0) begin
            mdl[a3] = wd;
        end
        #1;
    endtask

    // Monitor: the outputs are always valid, so every falling edge with a
    // pending expectation produces a comparison.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (RD1 !== e.e1 || RD2 !== e.e2) begin
                    n_errors++;
                    $display("FAIL rd[tag %0d]: RD1=%h RD2=%h expected RD1=%h RD2=%h",
                             e.tag, RD1, RD2, e.e1, e.e2);
                end
            end
        end
    end

    // Global time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic        r, we;
        logic [4:0]  a3, a1, a2;
        logic [31:0] wd;
        int          wait_cyc;
        n_checks  = 0;
        n_errors  = 0;
        stim_done = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        reset = 1'b1; WE = 1'b0; A3 = 5'd0; WD = 32'd0; A1 = 5'd0; A2 = 5'd0;
        #1;

        // Initial reset, not checked (contents before it are undefined).
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 0);

        // Reset state, then reset clear after writing R5.
        step(1'b0, 1'b0, 5'd7, 32'hCAFEF00D, 5'd5, 5'd31, 1'b1, 1);
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 2);
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 1'b1, 3);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 1'b1, 4);

        // $0 protection, during and after the write.
        step(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b1, 5);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 6);

        // Basic write/read (jal link).
        step(1'b0, 1'b1, 5'd31, 32'h00003004, 5'd31, 5'd30, 1'b1, 7);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd30, 1'b1, 8);

        // Same-cycle read of the written register, R8 previously 1.
        step(1'b0, 1'b1, 5'd8, 32'h00000001, 5'd8, 5'd8, 1'b1, 9);
        step(1'b0, 1'b1, 5'd8, 32'h0000ABCD, 5'd8, 5'd8, 1'b1, 10);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd8, 1'b1, 11);

        // Reset vs write collision.
        step(1'b1, 1'b1, 5'd9, 32'hFFFFFFFF, 5'd9, 5'd0, 1'b1, 12);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b1, 13);

        // WE gating, then last-write-wins.
        step(1'b0, 1'b0, 5'd4, 32'h00000055, 5'd4, 5'd4, 1'b1, 14);
        step(1'b0, 1'b1, 5'd4, 32'h00000001, 5'd4, 5'd0, 1'b1, 15);
        step(1'b0, 1'b1, 5'd4, 32'h00000002, 5'd4, 5'd0, 1'b1, 16);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 1'b1, 17);

        // Randomised traffic with frequent address collisions.
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 39) == 0);
            we = $urandom_range(0, 1);
            a3 = 5'($urandom_range(0, 31));
            wd = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            step(r, we, a3, wd, a1, a2, 1'b1, 100 + n);
        end

        // Drain the scoreboard with a bounded wait.
        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        stim_done = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
